arbitro_senales: RTL and testbench

Round-robin arbiter that shares one output channel among the four direction requests I1, I2, D1 and D2. It sits in front of the signalling state machine and grants the channel to exactly one requester at a time. Each grant lasts until the requester signals `done`, drops its request, or hits a programmable timeout. A one-cycle release gap separates consecutive grants so the downstream machine always sees a clean handover.

---
 rtl/arbitro_senales.sv | 122 ++++++++++++
 tb/tb_arbitro_senales.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_senales.sv
// Round-robin arbiter sharing one output channel among requesters I1, I2, D1, D2.
// Grants end on done, on a dropped request or on a programmable hold timeout.
module arbitro_senales #(
  parameter int unsigned TMAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       I1,
  input  logic       I2,
  input  logic       D1,
  input  logic       D2,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] Spres,
  output logic [1:0] Sfut
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TMAX - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] req;
  logic [1:0] last;
  logic [1:0] win;
  logic [1:0] winner;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic       any_req;
  logic       own_req;
  logic       hit_limit;
  logic       exit_grant;
  logic       exit_by_time;

  assign req     = {D2, D1, I2, I1};
  assign any_req = |req;
  assign own_req = req[win];

  // Rotating priority: scan from last+1 downward in distance so the nearest
  // requester after the previous grantee is the last one written.
  always_comb begin
    // NOTE: every always_comb variable gets a default first so no latch is inferred.
    winner = last + 2'd1;
    idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = last + 2'(k) + 2'd1;
      if (req[idx]) winner = idx;
    end
  end

  assign hit_limit    = (cnt == CNT_LAST);
  assign exit_grant   = done | ~own_req | hit_limit;
  // Timeout is flagged only when the counter alone ended the grant.
  assign exit_by_time = hit_limit & ~done & own_req;

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = any_req ? GRANT : IDLE;
      GRANT:   state_nx = exit_grant ? RELEASE : GRANT;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign Sfut  = state_nx;
  assign Spres = state;

  // NOTE: asynchronous reset clears every register, outputs included, without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= 8'd0;
      last    <= 2'd3;
      win     <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from pre-edge values.
      state   <= state_nx;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt  <= 4'b0001 << winner;
            win  <= winner;
            cnt  <= 8'd0;
            busy <= 1'b1;
          end
        end
        GRANT: begin
          if (exit_grant) begin
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            timeout <= exit_by_time;
            last    <= win;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RELEASE: begin
          gnt  <= 4'b0000;
          busy <= 1'b0;
        end
        default: begin
          gnt  <= 4'b0000;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_senales.sv
// Self-checking bench for arbitro_senales: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_arbitro_senales;

  localparam int TMAX = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       I1, I2, D1, D2, done;
  logic [3:0] gnt;
  logic       busy, timeout;
  logic [1:0] Spres, Sfut;

  int checks = 0;
  int errors = 0;

  arbitro_senales #(.TMAX(TMAX)) dut (
    .clk(clk), .reset(reset),
    .I1(I1), .I2(I2), .D1(D1), .D2(D2), .done(done),
    .gnt(gnt), .busy(busy), .timeout(timeout),
    .Spres(Spres), .Sfut(Sfut)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 channel owned, 2 handover gap.
  int m_phase, m_owner, m_held, m_last;
  bit m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_held = 0; m_last = 3; m_to = 0;
  endtask

  function automatic int next_phase(input logic [3:0] r, input logic d);
    if (m_phase == 0) return (r != 4'b0) ? 1 : 0;
    if (m_phase == 1) return (d || !r[m_owner] || m_held == TMAX) ? 2 : 1;
    return 0;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic d);
    bit found;
    int c;
    m_to = 0;
    case (m_phase)
      0: if (r != 4'b0) begin
           found = 0;
           for (int off = 1; off <= 4; off++) begin
             c = (m_last + off) % 4;
             if (!found && r[c]) begin m_owner = c; found = 1; end
           end
           m_held = 1;
           m_phase = 1;
         end
      1: if (d || !r[m_owner] || m_held == TMAX) begin
           m_to = !d && r[m_owner];
           m_last = m_owner;
           m_phase = 2;
         end else m_held++;
      default: m_phase = 0;
    endcase
  endtask

  task automatic drive(input logic [3:0] r, input logic d);
    {D2, D1, I2, I1} = r;
    done = d;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    logic [3:0] r;
    logic       d;
    logic [3:0] eg;
    r = {D2, D1, I2, I1};
    d = done;
    #1;
    check("sfut", 32'(Sfut), 32'(next_phase(r, d)));
    @(posedge clk);
    model_step(r, d);
    #1;
    eg = (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
    check("gnt", 32'(gnt), 32'(eg));
    check("busy", 32'(busy), 32'(m_phase == 1));
    check("timeout", 32'(timeout), 32'(m_to));
    check("spres", 32'(Spres), 32'(m_phase));
    @(negedge clk);
  endtask

  task automatic flush();
    drive(4'b0000, 1'b0);
    repeat (3) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] seq[$];
    logic [3:0] prev;
    logic [3:0] r;
    int run, tcount, to_cyc, regrant;
    int runs[$];

    reset = 1'b0;
    drive(4'b0000, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_spres", 32'(Spres), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b1;

    // Mid-grant reset clears outputs before any clock edge.
    drive(4'b0100, 1'b0);
    cycle();
    check("pre_rst_gnt", 32'(gnt), 32'h4);
    #2 reset = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_spres", 32'(Spres), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Round robin with all four requesting, done two cycles into each grant.
    prev = 4'b0000;
    for (int i = 0; i < 22; i++) begin
      drive(4'b1111, (m_phase == 1 && m_held == 2));
      cycle();
      if (gnt != 4'b0000 && prev == 4'b0000) seq.push_back(gnt);
      prev = gnt;
    end
    check("rr_count", 32'(seq.size() >= 5), 32'h1);
    if (seq.size() >= 5) begin
      check("rr_g0", 32'(seq[0]), 32'h1);
      check("rr_g1", 32'(seq[1]), 32'h2);
      check("rr_g2", 32'(seq[2]), 32'h4);
      check("rr_g3", 32'(seq[3]), 32'h8);
      check("rr_g4", 32'(seq[4]), 32'h1);
    end

    // Timeout with D1 alone.
    flush();
    run = 0; tcount = 0; to_cyc = -1; regrant = -1;
    for (int i = 0; i < 24; i++) begin
      drive(4'b0100, 1'b0);
      cycle();
      if (gnt == 4'b0100) run++;
      else if (run > 0) begin runs.push_back(run); run = 0; end
      if (timeout) tcount++;
      if (timeout && to_cyc < 0) to_cyc = i;
      if (to_cyc >= 0 && regrant < 0 && gnt == 4'b0100) regrant = i;
    end
    check("to_runs", 32'(runs.size() >= 2), 32'h1);
    if (runs.size() >= 2) begin
      check("to_len0", 32'(runs[0]), 32'd8);
      check("to_len1", 32'(runs[1]), 32'd8);
    end
    check("to_pulses", 32'(tcount), 32'd2);
    check("to_regrant", 32'(regrant - to_cyc), 32'd2);

    // Request drop: I2 granted, drops after 3 cycles; D2 wins next.
    flush();
    drive(4'b0010, 1'b0);
    cycle();
    drive(4'b1011, 1'b0);
    cycle();
    cycle();
    drive(4'b1001, 1'b0);
    cycle();
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_timeout", 32'(timeout), 32'h0);
    check("drop_last", 32'(dut.last), 32'd1);
    cycle();
    cycle();
    check("drop_next", 32'(gnt), 32'h8);

    // done on the same edge as the counter limit: no timeout.
    flush();
    drive(4'b0100, 1'b0);
    repeat (TMAX) cycle();
    drive(4'b0100, 1'b1);
    cycle();
    check("simul_timeout", 32'(timeout), 32'h0);
    check("simul_spres", 32'(Spres), 32'h2);
    drive(4'b0100, 1'b0);

    // No requests for 20 cycles.
    flush();
    for (int i = 0; i < 20; i++) begin
      drive(4'b0000, 1'b0);
      cycle();
    end
    check("idle_spres", 32'(Spres), 32'h0);

    // Random traffic against the model.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      drive(r, ($urandom_range(0, 7) == 0));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
